// File: rtl/memory_stage.sv
// Memory stage: accepts execute results, performs aligned dcache loads/stores through a
// four-state FSM (idle/request/wait/writeback) and presents one writeback beat per op.
module memory_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [XLEN-1:0] ex_alu_result_i,
  input  logic [XLEN-1:0] ex_store_data_i,
  input  logic            ex_mem_read_i,
  input  logic            ex_mem_write_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [4:0]      ex_dest_reg_i,
  input  logic            ex_reg_write_i,
  output logic            dcache_req_valid_o,
  output logic            dcache_req_write_o,
  input  logic            dcache_req_ready_i,
  output logic [XLEN-1:0] dcache_req_addr_o,
  output logic [XLEN-1:0] dcache_req_wdata_o,
  output logic [7:0]      dcache_req_wstrb_o,
  input  logic            dcache_resp_valid_i,
  input  logic [XLEN-1:0] dcache_resp_data_i,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_dest_reg_o,
  output logic            wb_reg_write_o,
  output logic            misaligned_fault_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StWb} state_e;

  state_e          state_q;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      funct3_q;
  logic [4:0]      dest_q;
  logic            reg_write_q;
  logic            is_store_q;
  logic            req_valid_q, req_write_q;
  logic [XLEN-1:0] req_addr_q, req_wdata_q;
  logic [7:0]      req_wstrb_q;
  logic            wb_valid_q, wb_reg_write_q, fault_q;
  logic [XLEN-1:0] wb_data_q;
  logic [4:0]      wb_dest_q;

  logic [2:0]      ex_off;
  logic            ex_misaligned;
  logic            ex_rd_write;
  logic [7:0]      size_strb;
  logic [XLEN-1:0] size_mask;
  logic [7:0]      st_wstrb;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_shifted;
  logic [XLEN-1:0] ld_value;

  always_comb begin
    ex_off      = ex_alu_result_i[2:0];
    ex_rd_write = ex_reg_write_i && (ex_dest_reg_i != 5'd0);
    unique case (ex_funct3_i[1:0])
      2'b00: begin size_strb = 8'h01; ex_misaligned = 1'b0;          end
      2'b01: begin size_strb = 8'h03; ex_misaligned = ex_off[0];     end
      2'b10: begin size_strb = 8'h0F; ex_misaligned = |ex_off[1:0];  end
      default: begin size_strb = 8'hFF; ex_misaligned = |ex_off;     end
    endcase
    size_mask = '0;
    for (int i = 0; i < 8; i++) size_mask[8*i +: 8] = {8{size_strb[i]}};
    st_wstrb = size_strb << ex_off;
    // Store bytes are masked to the access size before lane shifting so stray rs2 bits stay 0
    st_wdata = (ex_store_data_i & size_mask) << {ex_off, 3'b000};
  end

  always_comb begin
    ld_shifted = dcache_resp_data_i >> {addr_q[2:0], 3'b000};
    unique case (funct3_q)
      3'b000:  ld_value = {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_value = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
      3'b010:  ld_value = {{(XLEN-32){ld_shifted[31]}}, ld_shifted[31:0]};
      3'b100:  ld_value = {{(XLEN-8){1'b0}}, ld_shifted[7:0]};
      3'b101:  ld_value = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
      3'b110:  ld_value = {{(XLEN-32){1'b0}}, ld_shifted[31:0]};
      default: ld_value = ld_shifted;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      funct3_q       <= '0;
      dest_q         <= '0;
      reg_write_q    <= 1'b0;
      is_store_q     <= 1'b0;
      req_valid_q    <= 1'b0;
      req_write_q    <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_wstrb_q    <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      fault_q        <= 1'b0;
      wb_data_q      <= '0;
      wb_dest_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ex_valid_i) begin
            addr_q      <= ex_alu_result_i;
            funct3_q    <= ex_funct3_i;
            dest_q      <= ex_dest_reg_i;
            reg_write_q <= ex_rd_write;
            // Both read and write high is illegal; read wins
            is_store_q  <= ex_mem_write_i && !ex_mem_read_i;
            if (!ex_mem_read_i && !ex_mem_write_i) begin
              wb_valid_q     <= 1'b1;
              wb_data_q      <= ex_alu_result_i;
              wb_dest_q      <= ex_dest_reg_i;
              wb_reg_write_q <= ex_rd_write;
              fault_q        <= 1'b0;
              state_q        <= StWb;
            end else if (ex_misaligned) begin
              wb_valid_q     <= 1'b1;
              wb_data_q      <= ex_alu_result_i;
              wb_dest_q      <= ex_dest_reg_i;
              wb_reg_write_q <= 1'b0;
              fault_q        <= 1'b1;
              state_q        <= StWb;
            end else begin
              req_valid_q <= 1'b1;
              req_write_q <= !ex_mem_read_i;
              req_addr_q  <= {ex_alu_result_i[XLEN-1:3], 3'b000};
              req_wdata_q <= ex_mem_read_i ? '0 : st_wdata;
              req_wstrb_q <= ex_mem_read_i ? '0 : st_wstrb;
              state_q     <= StReq;
            end
          end
        end
        StReq: begin
          if (dcache_req_ready_i) begin
            req_valid_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (dcache_resp_valid_i) begin
            wb_valid_q     <= 1'b1;
            wb_data_q      <= is_store_q ? addr_q : ld_value;
            wb_dest_q      <= dest_q;
            wb_reg_write_q <= is_store_q ? 1'b0 : reg_write_q;
            fault_q        <= 1'b0;
            state_q        <= StWb;
          end
        end
        StWb: begin
          wb_valid_q <= 1'b0;
          fault_q    <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ex_ready_o         = (state_q == StIdle);
  assign dcache_req_valid_o = req_valid_q;
  assign dcache_req_write_o = req_write_q;
  assign dcache_req_addr_o  = req_addr_q;
  assign dcache_req_wdata_o = req_wdata_q;
  assign dcache_req_wstrb_o = req_wstrb_q;
  // Reset during writeback kills the beat in the same cycle
  assign wb_valid_o         = wb_valid_q && !reset_i;
  assign misaligned_fault_o = fault_q && !reset_i;
  assign wb_data_o          = wb_data_q;
  assign wb_dest_reg_o      = wb_dest_q;
  assign wb_reg_write_o     = wb_reg_write_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed ops push expected cache requests and writebacks,
// monitors pop and compare whenever the DUT presents them.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [63:0] ex_alu_result, ex_store_data;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_dest_reg;
  logic        req_valid, req_write, req_ready, resp_valid;
  logic [63:0] req_addr, req_wdata, resp_data;
  logic [7:0]  req_wstrb;
  logic        wb_valid, wb_reg_write, fault;
  logic [63:0] wb_data;
  logic [4:0]  wb_dest;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  dest;
    logic        rw;
    logic        fault;
  } wb_t;

  typedef struct {
    logic [63:0] addr;
    logic        write;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];

  memory_stage #(.XLEN(64)) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .ex_valid_i         (ex_valid),
    .ex_ready_o         (ex_ready),
    .ex_alu_result_i    (ex_alu_result),
    .ex_store_data_i    (ex_store_data),
    .ex_mem_read_i      (ex_mem_read),
    .ex_mem_write_i     (ex_mem_write),
    .ex_funct3_i        (ex_funct3),
    .ex_dest_reg_i      (ex_dest_reg),
    .ex_reg_write_i     (ex_reg_write),
    .dcache_req_valid_o (req_valid),
    .dcache_req_write_o (req_write),
    .dcache_req_ready_i (req_ready),
    .dcache_req_addr_o  (req_addr),
    .dcache_req_wdata_o (req_wdata),
    .dcache_req_wstrb_o (req_wstrb),
    .dcache_resp_valid_i(resp_valid),
    .dcache_resp_data_i (resp_data),
    .wb_valid_o         (wb_valid),
    .wb_data_o          (wb_data),
    .wb_dest_reg_o      (wb_dest),
    .wb_reg_write_o     (wb_reg_write),
    .misaligned_fault_o (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Writeback monitor
  always @(negedge clk) begin
    if (wb_valid) begin
      if (wb_q.size() == 0) begin
        check("unexpected_wb", 64'(wb_valid), 64'd0);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check("wb_data", wb_data, e.data);
        check("wb_dest", 64'(wb_dest), 64'(e.dest));
        check("wb_reg_write", 64'(wb_reg_write), 64'(e.rw));
        check("wb_fault", 64'(fault), 64'(e.fault));
      end
    end
  end

  // Cache request monitor
  always @(negedge clk) begin
    if (req_valid && req_ready) begin
      if (req_q.size() == 0) begin
        check("unexpected_req", 64'(req_valid), 64'd0);
      end else begin
        req_t r;
        r = req_q.pop_front();
        check("req_addr", req_addr, r.addr);
        check("req_write", 64'(req_write), 64'(r.write));
        if (r.write) begin
          check("req_wdata", req_wdata, r.wdata);
          check("req_wstrb", 64'(req_wstrb), 64'(r.wstrb));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [63:0] alu, input logic [63:0] sd, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
    int n = 0;
    while (!ex_ready && n < 20) begin tick(); n++; end
    if (!ex_ready) check("ex_ready_timeout", 64'(ex_ready), 64'd1);
    ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_dest_reg = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic serve(input int lag, input logic [63:0] data);
    int n = 0;
    while (!req_valid && n < 20) begin tick(); n++; end
    if (!req_valid) check("req_timeout", 64'(req_valid), 64'd1);
    repeat (lag) tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    tick();
    resp_valid = 1'b1; resp_data = data;
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!ex_ready && n < 20) begin tick(); n++; end
    if (!ex_ready) check("idle_timeout", 64'(ex_ready), 64'd1);
  endtask

  task automatic push_wb(input logic [63:0] d, input logic [4:0] rd, input logic rw,
                         input logic f);
    wb_t e;
    e.data = d; e.dest = rd; e.rw = rw; e.fault = f;
    wb_q.push_back(e);
  endtask

  task automatic push_req(input logic [63:0] a, input logic w, input logic [63:0] wd,
                          input logic [7:0] ws);
    req_t r;
    r.addr = a; r.write = w; r.wdata = wd; r.wstrb = ws;
    req_q.push_back(r);
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0; ex_dest_reg = '0;
    ex_reg_write = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_ex_ready", 64'(ex_ready), 64'd1);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_req_wstrb", 64'(req_wstrb), 64'd0);

    // Non-memory op, latency 1
    push_wb(64'h1234, 5'd5, 1'b1, 1'b0);
    do_op(64'h1234, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    check("alu_wb_valid_lat1", 64'(wb_valid), 64'd1);
    check("alu_ex_ready_in_wb", 64'(ex_ready), 64'd0);
    tick();
    check("alu_wb_valid_drop", 64'(wb_valid), 64'd0);
    check("alu_ex_ready_after", 64'(ex_ready), 64'd1);

    // Non-memory op to x0 does not write
    push_wb(64'hDEAD, 5'd0, 1'b0, 1'b0);
    do_op(64'hDEAD, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'b011);
    wait_idle();

    // LB sign-extends byte 3
    push_req(64'h1000, 1'b0, 64'd0, 8'd0);
    push_wb(64'hFFFF_FFFF_FFFF_FF80, 5'd7, 1'b1, 1'b0);
    do_op(64'h1003, 64'd0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000);
    serve(0, 64'h0000_0000_8000_0000);
    wait_idle();

    // SH at offset 6
    push_req(64'h2000, 1'b1, 64'hABCD_0000_0000_0000, 8'hC0);
    push_wb(64'h2006, 5'd0, 1'b0, 1'b0);
    do_op(64'h2006, 64'hABCD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001);
    serve(1, 64'd0);
    wait_idle();

    // Misaligned LW: no cache request, fault alongside wb
    push_wb(64'h3002, 5'd3, 1'b0, 1'b1);
    do_op(64'h3002, 64'd0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010);
    check("mis_no_req", 64'(req_valid), 64'd0);
    check("mis_wb_valid", 64'(wb_valid), 64'd1);
    check("mis_fault", 64'(fault), 64'd1);
    tick();
    check("mis_fault_pulse", 64'(fault), 64'd0);

    // LD with ready held low for 3 cycles
    push_req(64'h4008, 1'b0, 64'd0, 8'd0);
    push_wb(64'h1122_3344_5566_7788, 5'd9, 1'b1, 1'b0);
    do_op(64'h4008, 64'd0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b011);
    for (int i = 0; i < 4; i++) begin
      req_ready = (i == 3);
      @(negedge clk);
      check("ld_hold_valid", 64'(req_valid), 64'd1);
      check("ld_hold_addr", req_addr, 64'h4008);
      check("ld_hold_ex_ready", 64'(ex_ready), 64'd0);
      tick();
    end
    req_ready = 1'b0;
    check("ld_wait_ex_ready", 64'(ex_ready), 64'd0);
    resp_valid = 1'b1; resp_data = 64'h1122_3344_5566_7788;
    tick();
    resp_valid = 1'b0;
    check("ld_wb_ex_ready", 64'(ex_ready), 64'd0);
    wait_idle();

    // LHU zero-extends, LW sign-extends upper word, load to x0 suppresses write
    push_req(64'h5000, 1'b0, 64'd0, 8'd0);
    push_wb(64'h0000_0000_0000_F00D, 5'd10, 1'b1, 1'b0);
    do_op(64'h5002, 64'd0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b101);
    serve(0, 64'h0000_0000_F00D_0000);
    wait_idle();
    push_req(64'h5000, 1'b0, 64'd0, 8'd0);
    push_wb(64'hFFFF_FFFF_8765_4321, 5'd0, 1'b0, 1'b0);
    do_op(64'h5004, 64'd0, 5'd0, 1'b1, 1'b1, 1'b0, 3'b010);
    serve(0, 64'h8765_4321_0000_0000);
    wait_idle();

    // SB and SW lane placement with stray rs2 bits
    push_req(64'h6000, 1'b1, 64'h0000_5A00_0000_0000, 8'h20);
    push_wb(64'h6005, 5'd1, 1'b0, 1'b0);
    do_op(64'h6005, 64'hFFFF_FFFF_FFFF_FF5A, 5'd1, 1'b1, 1'b0, 1'b1, 3'b000);
    serve(0, 64'd0);
    wait_idle();
    push_req(64'h6000, 1'b1, 64'h5566_7788_0000_0000, 8'hF0);
    push_wb(64'h6004, 5'd2, 1'b0, 1'b0);
    do_op(64'h6004, 64'h1122_3344_5566_7788, 5'd2, 1'b0, 1'b0, 1'b1, 3'b010);
    serve(0, 64'd0);
    wait_idle();

    // Response while idle is ignored
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    check("idle_resp_ignored", 64'(wb_valid), 64'd0);

    // Reset in WAIT abandons the load; late response ignored
    push_req(64'h7000, 1'b0, 64'd0, 8'd0);
    do_op(64'h7000, 64'd0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b011);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_ex_ready", 64'(ex_ready), 64'd1);
    check("rw_req_valid", 64'(req_valid), 64'd0);
    resp_valid = 1'b1; resp_data = 64'h55;
    tick();
    resp_valid = 1'b0;
    check("rw_no_wb", 64'(wb_valid), 64'd0);
    tick();
    check("rw_no_wb_late", 64'(wb_valid), 64'd0);

    // Reset in WB suppresses the beat
    do_op(64'h8888, 64'd0, 5'd6, 1'b1, 1'b0, 1'b0, 3'b000);
    reset = 1'b1;
    #1;
    check("rwb_suppressed", 64'(wb_valid), 64'd0);
    tick();
    reset = 1'b0;
    check("rwb_ex_ready", 64'(ex_ready), 64'd1);
    check("rwb_wb_valid", 64'(wb_valid), 64'd0);

    repeat (2) tick();
    check("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    check("req_queue_drained", 64'(req_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width; only 64 is supported.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 ex_valid  input  1  execute result present (execute-done).
REQ-005 ex_ready  output  1  stage accepts ex_* this cycle.
REQ-006 ex_alu_result  input  64  ALU result; effective address for loads/stores.
REQ-007 ex_store_data  input  64  rs2 contents for stores.
REQ-008 ex_mem_read, ex_mem_write  input  1 each  load / store op; both high is illegal.
REQ-009 ex_funct3  input  3  access size/sign (RV64 encoding).
REQ-010 ex_dest_reg  input  5  destination register; ex_reg_write input 1 writes rd.
REQ-011 dcache_req_valid, dcache_req_write  output  1 each  request valid / store.
REQ-012 dcache_req_ready  input  1  cache accepts request.
REQ-013 dcache_req_addr  output  64  doubleword-aligned address (bits [2:0] = 0).
REQ-014 dcache_req_wdata  output  64; dcache_req_wstrb  output  8  byte-lane data/strobes.
REQ-015 dcache_resp_valid  input  1; dcache_resp_data  input  64  aligned doubleword response.
REQ-016 wb_valid  output  1; wb_data  output  64; wb_dest_reg  output  5; wb_reg_write  output  1.
REQ-017 misaligned_fault  output  1  one-cycle pulse alongside wb_valid for a faulting op.

Function
REQ-018 FSM states IDLE, REQ, WAIT, WB; ex_ready = (state == IDLE).
REQ-019 A handshake occurs when ex_valid && ex_ready; all ex_* fields are latched on that edge.
REQ-020 Non-memory op: IDLE -> WB; wb_data = latched ex_alu_result; wb_valid high exactly one cycle (latency 1).
REQ-021 Memory op, aligned: IDLE -> REQ; dcache_req_valid is held with stable fields until dcache_req_ready, then REQ -> WAIT.
REQ-022 WAIT -> WB on dcache_resp_valid; response data is captured that edge; wb_valid asserts the next cycle.
REQ-023 WB -> IDLE unconditionally after one cycle; the next handshake is possible the cycle after WB.
REQ-024 Alignment: funct3[1:0] = 01 needs addr[0] = 0; 10 needs addr[1:0] = 0; 11 needs addr[2:0] = 0.
REQ-025 A misaligned op issues no cache request; the FSM goes IDLE -> WB with misaligned_fault = 1, wb_reg_write = 0, wb_data = address.
REQ-026 Load extraction: byte offset o = addr[2:0]; field = resp_data >> (8*o), truncated to size.
REQ-027 Load sign: funct3 000/001/010 sign-extend, 100/101/110 zero-extend, 011 full 64 bits; funct3 111 is treated as LD.
REQ-028 Store: wstrb = size mask (0x01/0x03/0x0F/0xFF) << o; wdata = store_data << (8*o); bytes outside wstrb are 0.
REQ-029 Store completes on dcache_resp_valid like a load; wb_reg_write = 0 and wb_data = address.
REQ-030 Load wb_reg_write = latched ex_reg_write && (ex_dest_reg != 0).
REQ-031 Non-memory op: wb_reg_write = latched ex_reg_write && (ex_dest_reg != 0).
REQ-032 dcache_resp_valid outside WAIT is ignored.
REQ-033 Inputs in states other than IDLE are ignored.

Reset
REQ-034 On reset the FSM goes to IDLE and all outputs are 0 the following cycle: wb_*, dcache_req_*, misaligned_fault; ex_ready = 1.
REQ-035 Reset in REQ/WAIT abandons the transaction; a late dcache_resp_valid after reset is ignored.
REQ-036 Reset in WB suppresses wb_valid.
REQ-037 No internal state survives reset.

Verification
REQ-038 Non-memory op, alu = 0x1234, rd = 5, reg_write = 1 -> wb_valid one cycle later, wb_data = 0x1234, wb_dest_reg = 5, wb_reg_write = 1.
REQ-039 LB at 0x1003, resp_data = 0x00000000_80000000 -> req_addr = 0x1000, wb_data = 0xFFFFFFFF_FFFFFF80.
REQ-040 SH at 0x2006, rs2 = 0xABCD -> wstrb = 0xC0, wdata = 0xABCD0000_00000000, wb_reg_write = 0.
REQ-041 LW at 0x3002 -> no dcache_req_valid, misaligned_fault = 1, wb_valid one cycle after handshake.
REQ-042 LD with dcache_req_ready low 3 cycles -> req fields stable for 4 cycles, ex_ready = 0 until after WB.
REQ-043 Reset asserted in WAIT, then resp_valid -> no wb_valid; ex_ready = 1 after reset.
